// File: rtl/bp_me_lce_id_to_cord_table.sv
// bp_me_lce_id_to_cord_table: programmable LCE ID -> {cid, y, x} table.
// The table is filled with the core-complex default mapping after reset, then firmware may rewrite it.
module bp_me_lce_id_to_cord_table #(
    parameter int num_entries_p       = 32,
    parameter int lce_id_width_p      = 6,
    parameter int x_cord_width_p      = 4,
    parameter int y_cord_width_p      = 4,
    parameter int cid_width_p         = 2,
    parameter int num_lookup_p        = 2,
    parameter int lce_per_tile_log2_p = 1,
    parameter int sac_x_dim_p         = 1,
    parameter int ic_y_dim_p          = 1,
    parameter int cc_x_dim_p          = 2
) (
    input  logic                                                   clk_i,
    input  logic                                                   reset_i,
    output logic                                                   init_done_o,
    input  logic [num_lookup_p-1:0]                                lookup_v_i,
    input  logic [num_lookup_p*lce_id_width_p-1:0]                 lookup_id_i,
    output logic                                                   lookup_ready_o,
    output logic [num_lookup_p-1:0]                                lookup_v_o,
    output logic [num_lookup_p*(x_cord_width_p+y_cord_width_p)-1:0] lookup_cord_o,
    output logic [num_lookup_p*cid_width_p-1:0]                    lookup_cid_o,
    output logic [num_lookup_p-1:0]                                lookup_err_o,
    input  logic                                                   w_v_i,
    input  logic [lce_id_width_p-1:0]                              w_id_i,
    input  logic [x_cord_width_p-1:0]                              w_x_i,
    input  logic [y_cord_width_p-1:0]                              w_y_i,
    input  logic [cid_width_p-1:0]                                 w_cid_i,
    output logic                                                   w_ready_o
);
    localparam int idx_w_lp  = $clog2(num_entries_p);
    localparam int cord_w_lp = x_cord_width_p + y_cord_width_p;
    localparam int ent_w_lp  = cord_w_lp + cid_width_p;

    typedef enum logic {e_init, e_ready} state_e;

    state_e                state_q, state_d;
    logic [idx_w_lp-1:0]   cnt_q, cnt_d;
    logic                  ready_q;
    logic [ent_w_lp-1:0]   tbl_q [num_entries_p];
    logic                  tbl_we, w_ok;
    logic [idx_w_lp-1:0]   tbl_wa;
    logic [ent_w_lp-1:0]   tbl_wd, def_ent;
    logic [31:0]           def_t;

    logic [lce_id_width_p-1:0] lk_id  [num_lookup_p];
    logic [ent_w_lp-1:0]       lk_ent [num_lookup_p];
    logic [num_lookup_p-1:0]   lk_oor;
    logic [num_lookup_p-1:0]   v_q, err_q;
    logic [cord_w_lp-1:0]      cord_q [num_lookup_p];
    logic [cid_width_p-1:0]    cid_q  [num_lookup_p];

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= e_init;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= (state_d == e_ready);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == e_init) begin
            cnt_d = cnt_q + idx_w_lp'(1);
            if (cnt_q == idx_w_lp'(num_entries_p - 1)) state_d = e_ready;
        end
    end

    // Default mapping is evaluated at 32 bits, then each field is truncated.
    always_comb begin
        def_t   = 32'(cnt_q) >> lce_per_tile_log2_p;
        def_ent = {cid_width_p'(32'(cnt_q) % (32'd1 << lce_per_tile_log2_p)),
                   y_cord_width_p'(32'(ic_y_dim_p) + def_t / 32'(cc_x_dim_p)),
                   x_cord_width_p'(32'(sac_x_dim_p) + def_t % 32'(cc_x_dim_p))};
        w_ok    = w_v_i & ready_q & (w_id_i < lce_id_width_p'(num_entries_p));
        tbl_we  = (state_q == e_init) | w_ok;
        tbl_wa  = (state_q == e_init) ? cnt_q : w_id_i[idx_w_lp-1:0];
        tbl_wd  = (state_q == e_init) ? def_ent : {w_cid_i, w_y_i, w_x_i};
    end

    always_ff @(posedge clk_i) begin
        if (tbl_we) tbl_q[tbl_wa] <= tbl_wd;
    end

    genvar c;
    generate
        for (c = 0; c < num_lookup_p; c++) begin : g_ch
            assign lk_id[c]  = lookup_id_i[c*lce_id_width_p +: lce_id_width_p];
            assign lk_oor[c] = lk_id[c] >= lce_id_width_p'(num_entries_p);
            assign lk_ent[c] = lk_oor[c] ? '0 : tbl_q[lk_id[c][idx_w_lp-1:0]];
            assign lookup_cord_o[c*cord_w_lp +: cord_w_lp]    = cord_q[c];
            assign lookup_cid_o[c*cid_width_p +: cid_width_p] = cid_q[c];
        end
    endgenerate

    // Table reads see the pre-edge contents, giving read-before-write on collisions.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_q   <= '0;
            err_q <= '0;
            for (int i = 0; i < num_lookup_p; i++) begin
                cord_q[i] <= '0;
                cid_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < num_lookup_p; i++) begin
                v_q[i] <= lookup_v_i[i] & ready_q;
                if (lookup_v_i[i] & ready_q) begin
                    err_q[i]  <= lk_oor[i];
                    cord_q[i] <= lk_ent[i][cord_w_lp-1:0];
                    cid_q[i]  <= lk_ent[i][ent_w_lp-1:cord_w_lp];
                end
            end
        end
    end

    assign init_done_o    = ready_q;
    assign lookup_ready_o = ready_q;
    assign w_ready_o      = ready_q;
    assign lookup_v_o     = v_q;
    assign lookup_err_o   = err_q;
endmodule

// File: tb/tb_bp_me_lce_id_to_cord_table.sv
// tb_bp_me_lce_id_to_cord_table: randomized self-checking bench against an array reference table.
module tb_bp_me_lce_id_to_cord_table;
    localparam int N = 32, XW = 4, YW = 4, CW = 2, LPT = 1, SAC = 1, ICY = 1, CCX = 2;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        init_done_o, lookup_ready_o, w_ready_o;
    logic [1:0]  lookup_v_i, lookup_v_o, lookup_err_o;
    logic [11:0] lookup_id_i;
    logic [15:0] lookup_cord_o;
    logic [3:0]  lookup_cid_o;
    logic        w_v_i;
    logic [5:0]  w_id_i;
    logic [3:0]  w_x_i, w_y_i;
    logic [1:0]  w_cid_i;

    int errors = 0, checks = 0;
    int mx[N], my[N], mc[N];

    always #5 clk = ~clk;

    bp_me_lce_id_to_cord_table dut (
        .clk_i(clk), .reset_i(reset_i), .init_done_o(init_done_o),
        .lookup_v_i(lookup_v_i), .lookup_id_i(lookup_id_i), .lookup_ready_o(lookup_ready_o),
        .lookup_v_o(lookup_v_o), .lookup_cord_o(lookup_cord_o), .lookup_cid_o(lookup_cid_o),
        .lookup_err_o(lookup_err_o), .w_v_i(w_v_i), .w_id_i(w_id_i), .w_x_i(w_x_i),
        .w_y_i(w_y_i), .w_cid_i(w_cid_i), .w_ready_o(w_ready_o)
    );

    function automatic void model_default();
        for (int i = 0; i < N; i++) begin
            int t = i / (1 << LPT);
            mx[i] = (SAC + t % CCX) % (1 << XW);
            my[i] = (ICY + t / CCX) % (1 << YW);
            mc[i] = (i % (1 << LPT)) % (1 << CW);
        end
    endfunction

    function automatic logic [7:0] exp_cord(int id);
        return (id >= N) ? 8'd0 : 8'(my[id] * (1 << XW) + mx[id]);
    endfunction

    function automatic logic [1:0] exp_cid(int id);
        return (id >= N) ? 2'd0 : 2'(mc[id]);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_init(input string name);
        int done_at = 0;
        for (int k = 1; k <= 40 && done_at == 0; k++) begin
            tick();
            if (init_done_o) done_at = k;
            else begin
                checks++;
                if (lookup_v_o !== 2'b00) begin errors++; $display("FAIL %s_v_during_init: got %b want 00", name, lookup_v_o); end
            end
        end
        checks++;
        if (done_at != 32) begin errors++; $display("FAIL %s_init_cycles: got %0d want 32", name, done_at); end
        checks++;
        if ({lookup_ready_o, w_ready_o} !== 2'b11) begin errors++; $display("FAIL %s_ready: got %b want 11", name, {lookup_ready_o, w_ready_o}); end
        lookup_v_i = 2'b00;
        model_default();
    endtask

    task automatic test_reset();
        reset_i = 1'b1; lookup_v_i = '0; lookup_id_i = '0; w_v_i = 1'b0;
        w_id_i = '0; w_x_i = '0; w_y_i = '0; w_cid_i = '0;
        repeat (3) tick();
        checks++;
        if ({init_done_o, lookup_ready_o, w_ready_o, lookup_v_o, lookup_err_o, lookup_cord_o, lookup_cid_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b v=%b err=%b cord=%h cid=%h want all 0", init_done_o, lookup_v_o, lookup_err_o, lookup_cord_o, lookup_cid_o);
        end
        lookup_v_i = 2'b11; lookup_id_i = {6'd3, 6'd2};
        reset_i = 1'b0;
        wait_init("reset");
    endtask

    task automatic test_lookup();
        lookup_v_i = 2'b11; lookup_id_i = {6'd0, 6'd5};
        tick();
        lookup_v_i = 2'b00;
        checks++;
        if (lookup_v_o !== 2'b11) begin errors++; $display("FAIL lookup_v: got %b want 11", lookup_v_o); end
        checks++;
        if ({lookup_cord_o, lookup_cid_o, lookup_err_o} !== {8'h11, 8'h21, 2'd0, 2'd1, 2'b00}) begin
            errors++; $display("FAIL lookup_data: got cord=%h cid=%h err=%b want cord=1121 cid=1 err=00", lookup_cord_o, lookup_cid_o, lookup_err_o);
        end
        tick();
        checks++;
        if (lookup_v_o !== 2'b00) begin errors++; $display("FAIL lookup_v_one_cycle: got %b want 00", lookup_v_o); end
        checks++;
        if (lookup_cord_o !== 16'h1121 || lookup_cid_o !== 4'h1) begin
            errors++; $display("FAIL lookup_hold: got cord=%h cid=%h want 1121/1", lookup_cord_o, lookup_cid_o);
        end
    endtask

    task automatic test_rbw();
        lookup_v_i = 2'b01; lookup_id_i = {6'd0, 6'd5};
        w_v_i = 1'b1; w_id_i = 6'd5; w_x_i = 4'd7; w_y_i = 4'd3; w_cid_i = 2'd2;
        tick();
        w_v_i = 1'b0;
        mx[5] = 7; my[5] = 3; mc[5] = 2;
        checks++;
        if (lookup_v_o !== 2'b01 || lookup_cord_o[7:0] !== 8'h21 || lookup_cid_o[1:0] !== 2'd1) begin
            errors++; $display("FAIL rbw_old: got v=%b cord=%h cid=%0d want v=01 cord=21 cid=1", lookup_v_o, lookup_cord_o[7:0], lookup_cid_o[1:0]);
        end
        tick();
        lookup_v_i = 2'b00;
        checks++;
        if (lookup_v_o !== 2'b01 || lookup_cord_o[7:0] !== 8'h37 || lookup_cid_o[1:0] !== 2'd2) begin
            errors++; $display("FAIL rbw_new: got v=%b cord=%h cid=%0d want v=01 cord=37 cid=2", lookup_v_o, lookup_cord_o[7:0], lookup_cid_o[1:0]);
        end
    endtask

    task automatic test_out_of_range();
        lookup_v_i = 2'b10; lookup_id_i = {6'd40, 6'd5};
        tick();
        lookup_v_i = 2'b00;
        checks++;
        if (lookup_v_o !== 2'b10 || lookup_err_o[1] !== 1'b1 || lookup_cord_o[15:8] !== 8'h00 || lookup_cid_o[3:2] !== 2'd0) begin
            errors++; $display("FAIL oor_lookup: got v=%b err=%b cord=%h cid=%0d want v=10 err=1x cord=00 cid=0", lookup_v_o, lookup_err_o, lookup_cord_o[15:8], lookup_cid_o[3:2]);
        end
        w_v_i = 1'b1; w_id_i = 6'd40; w_x_i = 4'hf; w_y_i = 4'hf; w_cid_i = 2'd3;
        tick();
        w_v_i = 1'b0;
        for (int id = 0; id < N; id += 2) begin
            lookup_v_i = 2'b11; lookup_id_i = {6'(id + 1), 6'(id)};
            tick();
            checks++;
            if (lookup_v_o !== 2'b11 || lookup_err_o !== 2'b00 ||
                lookup_cord_o !== {exp_cord(id + 1), exp_cord(id)} || lookup_cid_o !== {exp_cid(id + 1), exp_cid(id)}) begin
                errors++;
                $display("FAIL oor_write_dropped id=%0d: got v=%b err=%b cord=%h cid=%h want 11/00/%h/%h", id, lookup_v_o, lookup_err_o,
                         lookup_cord_o, lookup_cid_o, {exp_cord(id + 1), exp_cord(id)}, {exp_cid(id + 1), exp_cid(id)});
            end
        end
        lookup_v_i = 2'b00;
    endtask

    task automatic test_reset_mid_init();
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        repeat (10) tick();
        checks++;
        if (init_done_o !== 1'b0) begin errors++; $display("FAIL mid_init_done: got %b want 0", init_done_o); end
        reset_i = 1'b1;
        #1;
        checks++;
        if ({init_done_o, lookup_v_o, lookup_cord_o} !== '0) begin errors++; $display("FAIL mid_reset_clear: got done=%b v=%b cord=%h want 0", init_done_o, lookup_v_o, lookup_cord_o); end
        tick();
        reset_i = 1'b0;
        wait_init("mid_reset");
        lookup_v_i = 2'b11; lookup_id_i = {6'd0, 6'd5};
        tick();
        lookup_v_i = 2'b00;
        checks++;
        if (lookup_cord_o !== 16'h1121 || lookup_cid_o !== 4'h1 || lookup_err_o !== 2'b00) begin
            errors++; $display("FAIL mid_reset_revert: got cord=%h cid=%h err=%b want 1121/1/00", lookup_cord_o, lookup_cid_o, lookup_err_o);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] ec[2];
        logic [1:0] ecid[2];
        logic       eerr[2];
        int         id[2];
        logic [1:0] lv;
        for (int i = 0; i < 1000; i++) begin
            lv = (i == 0) ? 2'b11 : 2'($urandom_range(0, 3));
            id[0] = $urandom_range(0, 39);
            id[1] = ($urandom_range(0, 3) == 0) ? id[0] : $urandom_range(0, 39);
            lookup_v_i = lv; lookup_id_i = {6'(id[1]), 6'(id[0])};
            w_v_i = ($urandom_range(0, 2) == 0); w_id_i = 6'($urandom_range(0, 39));
            w_x_i = 4'($urandom); w_y_i = 4'($urandom); w_cid_i = 2'($urandom);
            for (int ch = 0; ch < 2; ch++) begin
                if (lv[ch]) begin
                    ec[ch] = exp_cord(id[ch]); ecid[ch] = exp_cid(id[ch]); eerr[ch] = (id[ch] >= N);
                end
            end
            tick();
            if (w_v_i && w_id_i < N) begin mx[w_id_i] = w_x_i; my[w_id_i] = w_y_i; mc[w_id_i] = w_cid_i; end
            checks++;
            if (lookup_v_o !== lv) begin errors++; $display("FAIL rand_v cyc=%0d: got %b want %b", i, lookup_v_o, lv); end
            for (int ch = 0; ch < 2; ch++) begin
                checks++;
                if (lookup_cord_o[ch*8 +: 8] !== ec[ch]) begin errors++; $display("FAIL rand_cord cyc=%0d ch=%0d: got %h want %h", i, ch, lookup_cord_o[ch*8 +: 8], ec[ch]); end
                checks++;
                if (lookup_cid_o[ch*2 +: 2] !== ecid[ch]) begin errors++; $display("FAIL rand_cid cyc=%0d ch=%0d: got %0d want %0d", i, ch, lookup_cid_o[ch*2 +: 2], ecid[ch]); end
                checks++;
                if (lookup_err_o[ch] !== eerr[ch]) begin errors++; $display("FAIL rand_err cyc=%0d ch=%0d: got %b want %b", i, ch, lookup_err_o[ch], eerr[ch]); end
            end
        end
        lookup_v_i = 2'b00; w_v_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lookup();
        test_rbw();
        test_out_of_range();
        test_reset_mid_init();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
